plru_way_select: RTL and testbench

- Pseudo-LRU replacement engine for the 8-way set-associative L2 model.
- Keeps per-set tree-PLRU state and per-way valid bits.
- On request, returns a registered 3-bit victim way. That way drives the 3-bit select of the downstream 8:1 way multiplexor, and the fill/eviction datapath.
- Updated by hit/fill "touch" events and invalidations from the cache controller.

---
 rtl/plru_way_select.sv | 97 +++++++++
 tb/tb_plru_way_select.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/plru_way_select.sv
// plru_way_select: per-set tree-PLRU and valid tracking with a registered 8-way victim lookup.
module plru_way_select #(
    parameter int SET_BITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    input  logic [SET_BITS-1:0] req_set,
    output logic                victim_valid,
    output logic [2:0]          victim_way,
    output logic                victim_free,
    input  logic                touch_valid,
    input  logic                touch_fill,
    input  logic [SET_BITS-1:0] touch_set,
    input  logic [2:0]          touch_way,
    input  logic                inval_valid,
    input  logic [SET_BITS-1:0] inval_set,
    input  logic [2:0]          inval_way,
    input  logic                flush
);
    localparam int SETS = 2 ** SET_BITS;

    logic [6:0] plru  [SETS];
    logic [7:0] valid [SETS];
    logic [6:0] req_plru;
    logic [7:0] req_valid_bits;
    logic [3:0] leaf;
    logic [2:0] walk_way;
    logic [2:0] free_way;
    logic       any_free;
    logic [6:0] touch_next;

    assign req_plru       = plru[req_set];
    assign req_valid_bits = valid[req_set];
    assign leaf           = req_plru[6:3];

    always_comb begin
        walk_way[2] = req_plru[0];
        walk_way[1] = walk_way[2] ? req_plru[2] : req_plru[1];
        walk_way[0] = leaf[walk_way[2:1]];
    end

    // Scan downwards so the lowest-index invalid way is the last one kept.
    always_comb begin
        free_way = 3'd0;
        any_free = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (!req_valid_bits[i]) begin
                free_way = 3'(i);
                any_free = 1'b1;
            end
        end
    end

    always_comb begin
        touch_next = plru[touch_set];
        touch_next[0] = ~touch_way[2];
        if (touch_way[2])
            touch_next[2] = ~touch_way[1];
        else
            touch_next[1] = ~touch_way[1];
        touch_next[3'd3 + 3'(touch_way[2:1])] = ~touch_way[0];
    end

    // The invalidate is written after the fill so it wins on a same-way collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                plru[s]  <= '0;
                valid[s] <= '0;
            end
            victim_valid <= 1'b0;
            victim_way   <= 3'd0;
            victim_free  <= 1'b0;
        end else begin
            victim_valid <= req_valid;
            if (req_valid) begin
                victim_way  <= any_free ? free_way : walk_way;
                victim_free <= any_free;
            end
            if (flush) begin
                for (int s = 0; s < SETS; s++) begin
                    plru[s]  <= '0;
                    valid[s] <= '0;
                end
            end else begin
                if (touch_valid) begin
                    plru[touch_set] <= touch_next;
                    if (touch_fill)
                        valid[touch_set][touch_way] <= 1'b1;
                end
                if (inval_valid)
                    valid[inval_set][inval_way] <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_plru_way_select.sv
// tb_plru_way_select: directed checks of victim selection, touch/invalidate interplay, flush and reset.
module tb_plru_way_select;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic [3:0] req_set;
    logic       victim_valid;
    logic [2:0] victim_way;
    logic       victim_free;
    logic       touch_valid;
    logic       touch_fill;
    logic [3:0] touch_set;
    logic [2:0] touch_way;
    logic       inval_valid;
    logic [3:0] inval_set;
    logic [2:0] inval_way;
    logic       flush;
    int total = 0;
    int bad   = 0;

    plru_way_select #(.SET_BITS(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_set(req_set),
        .victim_valid(victim_valid), .victim_way(victim_way), .victim_free(victim_free),
        .touch_valid(touch_valid), .touch_fill(touch_fill), .touch_set(touch_set), .touch_way(touch_way),
        .inval_valid(inval_valid), .inval_set(inval_set), .inval_way(inval_way),
        .flush(flush)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        req_valid   = 1'b0;
        touch_valid = 1'b0;
        touch_fill  = 1'b0;
        inval_valid = 1'b0;
        flush       = 1'b0;
    endtask

    // Compares {victim_valid, victim_way, victim_free}.
    task automatic chk(input string tag, input logic [4:0] exp);
        logic [4:0] obs;
        obs = {victim_valid, victim_way, victim_free};
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed vv/way/free=%b/%0d/%b expected %b/%0d/%b",
                   tag, obs[4], obs[3:1], obs[0], exp[4], exp[3:1], exp[0]);
        end
    endtask

    task automatic req(input logic [3:0] s);
        req_valid = 1'b1;
        req_set   = s;
    endtask

    task automatic touch(input logic [3:0] s, input logic [2:0] w, input logic f);
        touch_valid = 1'b1;
        touch_fill  = f;
        touch_set   = s;
        touch_way   = w;
    endtask

    task automatic inval(input logic [3:0] s, input logic [2:0] w);
        inval_valid = 1'b1;
        inval_set   = s;
        inval_way   = w;
    endtask

    task automatic fill_set(input logic [3:0] s);
        for (int w = 0; w < 8; w++) begin
            touch(s, 3'(w), 1'b1);
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 0; req_set = 0;
        touch_valid = 0; touch_fill = 0; touch_set = 0; touch_way = 0;
        inval_valid = 0; inval_set = 0; inval_way = 0; flush = 0;
        #12;
        chk("reset_state", 5'b0_000_0);
        rst_n = 1'b1;
        tick();
        tick();
        chk("idle_after_reset", 5'b0_000_0);

        req(4'd3); tick();
        chk("empty_set3", 5'b1_000_1);
        tick();
        chk("single_cycle_hold", 5'b0_000_1);

        fill_set(4'd3);
        chk("no_resp_during_fill", 5'b0_000_1);
        req(4'd3); tick();
        chk("full_set3_walk", 5'b1_000_0);
        touch(4'd3, 3'd0, 1'b0); tick();
        req(4'd3); tick();
        chk("after_touch0", 5'b1_100_0);

        inval(4'd3, 3'd5); tick();
        req(4'd3); tick();
        chk("inval_way5", 5'b1_101_1);
        req(4'd2); tick();
        chk("set2_untouched", 5'b1_000_1);

        fill_set(4'd4);
        touch(4'd4, 3'd0, 1'b0); req(4'd4); tick();
        chk("no_bypass_touch", 5'b1_000_0);
        req(4'd4); tick();
        chk("post_touch_walk", 5'b1_100_0);

        for (int w = 0; w < 8; w++) begin
            if (w != 6) begin
                touch(4'd1, 3'(w), 1'b1);
                tick();
            end
        end
        touch(4'd1, 3'd6, 1'b1); inval(4'd1, 3'd6); tick();
        req(4'd1); tick();
        chk("inval_beats_fill", 5'b1_110_1);
        req(4'd3); tick();
        chk("back_to_back", 5'b1_101_1);

        touch(4'd2, 3'd0, 1'b1); inval(4'd4, 3'd3); tick();
        req(4'd2); tick();
        chk("diff_set_fill", 5'b1_001_1);
        req(4'd4); tick();
        chk("diff_set_inval", 5'b1_011_1);

        for (int s = 0; s < 16; s++) fill_set(4'(s));
        req(4'd9); tick();
        chk("all_full_set9", 5'b1_000_0);
        flush = 1'b1; touch(4'd7, 3'd0, 1'b1); req(4'd9); tick();
        chk("req_in_flush_cycle", 5'b1_000_0);
        req(4'd9); tick();
        chk("post_flush_set9", 5'b1_000_1);
        req(4'd15); tick();
        chk("post_flush_set15", 5'b1_000_1);
        req(4'd7); tick();
        chk("flush_beats_touch", 5'b1_000_1);

        fill_set(4'd0);
        touch(4'd0, 3'd7, 1'b0); tick();
        req(4'd0); tick();
        chk("pre_reset_resp", 5'b1_000_0);
        req(4'd0); tick();
        chk("pre_reset_resp2", 5'b1_000_0);
        rst_n = 1'b0;
        #1;
        chk("async_reset_drop", 5'b0_000_0);
        rst_n = 1'b1;
        tick();
        req(4'd0);
        #2;
        rst_n = 1'b0;
        tick();
        chk("reset_kills_pending", 5'b0_000_0);
        rst_n = 1'b1;
        tick();
        req(4'd0); tick();
        chk("reset_cleared_state", 5'b1_000_1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
